// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage feeding the IF/ID pipeline register. It owns the
// program counter, issues requests to a variable-latency instruction memory
// and presents at most one instruction per cycle. A one-entry skid buffer
// absorbs the instruction that arrives in the cycle a stall begins. A branch
// flushes both entries and redirects the PC. If a fetch is still in flight
// when the branch arrives, its late acknowledge is discarded (DROP state).
//
// Parameters:
//   RESET_PC         PC loaded on reset (word-aligned)
//
// Ports:
//   clk_i            clock, all state updates on the rising edge
//   rst_n_i          asynchronous active-low reset
//   start_i          pipeline run enable (shared with IF/ID)
//   stall_i          IF/ID hold (shared with IF/ID)
//   branch_i         redirect / flush request
//   branch_target_i  redirect PC, low two bits ignored
//   imem_req_o       instruction memory request
//   imem_addr_o      request address (the internal PC)
//   imem_ack_i       read data valid this cycle while requesting
//   imem_rdata_i     instruction word from memory
//   inst_o           instruction to IF/ID, 32'h0 when the slot is empty
//   pc_o             PC of inst_o
//   inst_valid_o     output slot holds a real instruction
// ----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        inst_valid_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SKID  = 2'd2,
        ST_DROP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] slot_inst_q, slot_inst_d;
    logic [31:0] slot_pc_q, slot_pc_d;
    logic        slot_valid_q, slot_valid_d;
    logic [31:0] skid_inst_q, skid_inst_d;
    logic [31:0] skid_pc_q, skid_pc_d;

    logic        consume;
    logic [31:0] target_aligned;
    logic        unused_target_bits;

    // IF/ID takes the output slot at any edge where the pipeline runs
    // without a hold or a flush.
    assign consume            = start_i & ~stall_i & ~branch_i;
    assign target_aligned     = {branch_target_i[31:2], 2'b00};
    assign unused_target_bits = ^branch_target_i[1:0];

    // State, PC, output slot and skid buffer. The skid entry is valid
    // exactly while the FSM sits in ST_SKID, so it needs no valid flag.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            slot_inst_q  <= 32'h0;
            slot_pc_q    <= RESET_PC;
            slot_valid_q <= 1'b0;
            skid_inst_q  <= 32'h0;
            skid_pc_q    <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            slot_inst_q  <= slot_inst_d;
            slot_pc_q    <= slot_pc_d;
            slot_valid_q <= slot_valid_d;
            skid_inst_q  <= skid_inst_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    // Next-state and datapath updates. Branch is tested first in every
    // running state so it beats stall and acknowledge alike.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        slot_inst_d  = slot_inst_q;
        slot_pc_d    = slot_pc_q;
        slot_valid_d = slot_valid_q;
        skid_inst_d  = skid_inst_q;
        skid_pc_d    = skid_pc_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                if (branch_i) begin
                    slot_valid_d = 1'b0;
                    slot_inst_d  = 32'h0;
                    skid_inst_d  = 32'h0;
                    skid_pc_d    = 32'h0;
                    pc_d         = target_aligned;
                    // An unacknowledged request is still owed an ack by
                    // the memory; that ack must be swallowed.
                    state_d      = imem_ack_i ? ST_FETCH : ST_DROP;
                end else if (imem_ack_i) begin
                    pc_d = pc_q + 32'd4;
                    if (!slot_valid_q || consume) begin
                        slot_inst_d  = imem_rdata_i;
                        slot_pc_d    = pc_q;
                        slot_valid_d = 1'b1;
                    end else begin
                        skid_inst_d = imem_rdata_i;
                        skid_pc_d   = pc_q;
                        state_d     = ST_SKID;
                    end
                end else if (consume) begin
                    slot_valid_d = 1'b0;
                    slot_inst_d  = 32'h0;
                end
            end

            ST_SKID: begin
                if (branch_i) begin
                    slot_valid_d = 1'b0;
                    slot_inst_d  = 32'h0;
                    skid_inst_d  = 32'h0;
                    skid_pc_d    = 32'h0;
                    pc_d         = target_aligned;
                    state_d      = ST_FETCH;
                end else if (consume) begin
                    slot_inst_d  = skid_inst_q;
                    slot_pc_d    = skid_pc_q;
                    slot_valid_d = 1'b1;
                    skid_inst_d  = 32'h0;
                    skid_pc_d    = 32'h0;
                    state_d      = ST_FETCH;
                end
            end

            ST_DROP: begin
                // Slot and skid are already empty here; a further branch
                // only moves the PC and keeps waiting.
                if (branch_i) begin
                    pc_d = target_aligned;
                end else if (imem_ack_i) begin
                    state_d = ST_FETCH;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs come straight from registers or the state decode, never from
    // the memory inputs.
    assign imem_req_o   = (state_q == ST_FETCH) || (state_q == ST_DROP);
    assign imem_addr_o  = pc_q;
    assign inst_o       = slot_inst_q;
    assign pc_o         = slot_pc_q;
    assign inst_valid_o = slot_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_unit
//
// Drives fetch_unit with directed scenarios followed by randomized
// start/stall/branch traffic against a variable-latency memory model. The
// expected outputs come from a queue-based model: the output slot and the
// skid buffer are simply the first two entries of a queue of fetched words.
// A second instance with RESET_PC = 32'hFFFF_FFFC covers PC wrap-around.
// ----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic        start_i, stall_i, branch_i;
    logic [31:0] branch_target_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] inst_o, pc_o;
    logic        inst_valid_o;

    logic        w_start, w_stall, w_branch, w_ack;
    logic [31:0] w_target;
    logic        w_req, w_valid;
    logic [31:0] w_addr, w_rdata, w_inst, w_pc;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n_i),
        .start_i         (start_i),
        .stall_i         (stall_i),
        .branch_i        (branch_i),
        .branch_target_i (branch_target_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_ack_i      (imem_ack_i),
        .imem_rdata_i    (imem_rdata_i),
        .inst_o          (inst_o),
        .pc_o            (pc_o),
        .inst_valid_o    (inst_valid_o)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk_i           (clk),
        .rst_n_i         (rst_n_i),
        .start_i         (w_start),
        .stall_i         (w_stall),
        .branch_i        (w_branch),
        .branch_target_i (w_target),
        .imem_req_o      (w_req),
        .imem_addr_o     (w_addr),
        .imem_ack_i      (w_ack),
        .imem_rdata_i    (w_rdata),
        .inst_o          (w_inst),
        .pc_o            (w_pc),
        .inst_valid_o    (w_valid)
    );

    // Zero-wait memory for the wrap instance.
    assign w_rdata = w_addr ^ 32'hA5A5_0000;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    entry_t      mq[$];
    bit          m_running;
    bit          m_discard;
    logic [31:0] m_pc;

    bit          mem_busy;
    logic [31:0] mem_addr;
    int          mem_cnt;
    int          mem_delay;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic resetModel();
        mq.delete();
        m_running = 1'b0;
        m_discard = 1'b0;
        m_pc      = 32'h0;
        mem_busy  = 1'b0;
        mem_addr  = 32'h0;
        mem_cnt   = 0;
    endtask

    // The block wants memory while running, unless both slot and skid hold
    // data; while swallowing a stale ack it keeps the request raised.
    function automatic bit modelReq();
        return m_running && (m_discard || mq.size() < 2);
    endfunction

    task automatic checkOutput();
        bit req;
        req = modelReq();
        check("req", {31'b0, imem_req_o}, {31'b0, req});
        if (req) check("addr", imem_addr_o, m_pc);
        check("valid", {31'b0, inst_valid_o}, {31'b0, (mq.size() > 0)});
        if (mq.size() > 0) begin
            check("inst", inst_o, mq[0].inst);
            check("pc", pc_o, mq[0].pc);
        end else begin
            check("inst_empty", inst_o, 32'h0);
        end
    endtask

    // One clock cycle: memory response, model step, edge, compare.
    task automatic applyStimulus(input bit st, input bit sl, input bit br, input logic [31:0] tgt);
        bit     req_m;
        entry_t e;
        start_i         = st;
        stall_i         = sl;
        branch_i        = br;
        branch_target_i = tgt;

        if (imem_req_o && !mem_busy) begin
            mem_busy = 1'b1;
            mem_addr = imem_addr_o;
            mem_cnt  = mem_delay;
        end
        imem_ack_i   = imem_req_o && mem_busy && (mem_cnt == 0);
        imem_rdata_i = imem_ack_i ? (mem_addr ^ 32'hA5A5_0000) : $urandom;

        req_m = modelReq();
        if (!m_running) begin
            if (st) m_running = 1'b1;
        end else if (br) begin
            mq.delete();
            if (!m_discard) m_discard = req_m && !imem_ack_i;
            m_pc = {tgt[31:2], 2'b00};
        end else if (m_discard) begin
            if (imem_ack_i) m_discard = 1'b0;
        end else begin
            if (st && !sl && mq.size() > 0) void'(mq.pop_front());
            if (req_m && imem_ack_i) begin
                e.inst = imem_rdata_i;
                e.pc   = m_pc;
                mq.push_back(e);
                m_pc = m_pc + 32'd4;
            end
        end

        @(posedge clk);
        if (imem_ack_i) mem_busy = 1'b0;
        else if (mem_busy && mem_cnt > 0) mem_cnt--;
        #1;
        checkOutput();
    endtask

    initial begin
        bit found;
        rst_n_i         = 1'b0;
        start_i         = 1'b0;
        stall_i         = 1'b0;
        branch_i        = 1'b0;
        branch_target_i = 32'h0;
        imem_ack_i      = 1'b0;
        imem_rdata_i    = 32'h0;
        w_start         = 1'b0;
        w_stall         = 1'b0;
        w_branch        = 1'b0;
        w_target        = 32'h0;
        w_ack           = 1'b1;
        mem_delay       = 0;
        resetModel();

        // Reset state
        #12;
        check("rst_req", {31'b0, imem_req_o}, 32'h0);
        check("rst_inst", inst_o, 32'h0);
        check("rst_pc", pc_o, 32'h0);
        check("rst_valid", {31'b0, inst_valid_o}, 32'h0);
        check("rst_wrap_pc", w_pc, 32'hFFFF_FFFC);
        @(negedge clk);
        rst_n_i = 1'b1;
        @(posedge clk);
        #1;

        // Start and zero-wait stream
        applyStimulus(1, 0, 0, 32'h0);
        check("start_req", {31'b0, imem_req_o}, 32'h1);
        check("start_addr", imem_addr_o, 32'h0);
        applyStimulus(1, 0, 0, 32'h0);
        check("s0_inst", inst_o, 32'hA5A5_0000);
        check("s0_pc", pc_o, 32'h0);
        applyStimulus(1, 0, 0, 32'h0);
        check("s1_inst", inst_o, 32'hA5A5_0004);
        check("s1_pc", pc_o, 32'h4);

        // Stall for three cycles while PC 0x4 is shown
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 0, 32'h0);
            check("stall_pc", pc_o, 32'h4);
            check("stall_req", {31'b0, imem_req_o}, 32'h0);
        end
        applyStimulus(1, 0, 0, 32'h0);
        check("skid_pc", pc_o, 32'h8);
        check("skid_inst", inst_o, 32'hA5A5_0008);
        check("skid_next_addr", imem_addr_o, 32'hC);
        check("skid_next_req", {31'b0, imem_req_o}, 32'h1);

        // Branch while the slow request to 0x10 is outstanding
        mem_delay = 2;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (imem_req_o && imem_addr_o == 32'h10) found = 1'b1;
            else applyStimulus(1, 0, 0, 32'h0);
        end
        check("wait_addr10", {31'b0, found}, 32'h1);
        applyStimulus(1, 0, 1, 32'h103);
        check("br_valid", {31'b0, inst_valid_o}, 32'h0);
        check("br_inst", inst_o, 32'h0);
        check("br_addr", imem_addr_o, 32'h100);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            applyStimulus(1, 0, 0, 32'h0);
            if (inst_valid_o) found = 1'b1;
        end
        check("wait_target", {31'b0, found}, 32'h1);
        check("target_pc", pc_o, 32'h100);
        check("target_inst", inst_o, 32'hA5A5_0100);

        // Branch and stall on the same edge with the slot full
        mem_delay = 0;
        applyStimulus(1, 1, 1, 32'h200);
        check("brst_valid", {31'b0, inst_valid_o}, 32'h0);
        check("brst_addr", imem_addr_o, 32'h200);
        check("brst_req", {31'b0, imem_req_o}, 32'h1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            mem_delay = $urandom_range(0, 3);
            applyStimulus(($urandom_range(0, 9) != 0), ($urandom_range(0, 9) < 3),
                          ($urandom_range(0, 19) == 0), $urandom);
        end

        // Wrap-around instance and asynchronous reset mid-request
        rst_n_i = 1'b0;
        resetModel();
        #1;
        check("rst2_req", {31'b0, imem_req_o}, 32'h0);
        @(negedge clk);
        rst_n_i = 1'b1;
        @(posedge clk);
        #1;
        w_start   = 1'b1;
        mem_delay = 3;
        applyStimulus(1, 0, 0, 32'h0);
        check("wrap_req", {31'b0, w_req}, 32'h1);
        check("wrap_addr0", w_addr, 32'hFFFF_FFFC);
        applyStimulus(1, 0, 0, 32'h0);
        check("wrap_valid", {31'b0, w_valid}, 32'h1);
        check("wrap_inst0", w_inst, 32'h5A5A_FFFC);
        check("wrap_pc0", w_pc, 32'hFFFF_FFFC);
        check("wrap_addr1", w_addr, 32'h0);
        applyStimulus(1, 0, 0, 32'h0);
        check("wrap_inst1", w_inst, 32'hA5A5_0000);
        check("wrap_pc1", w_pc, 32'h0);
        check("mid_req_before", {31'b0, imem_req_o}, 32'h1);
        #2;
        rst_n_i = 1'b0;
        #1;
        check("async_req", {31'b0, imem_req_o}, 32'h0);
        check("async_pc", pc_o, 32'h0);
        check("async_wrap_req", {31'b0, w_req}, 32'h0);
        check("async_wrap_valid", {31'b0, w_valid}, 32'h0);
        check("async_wrap_pc", w_pc, 32'hFFFF_FFFC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the program counter, issues requests to a variable-latency instruction memory, and presents one instruction per cycle to IF/ID. It absorbs downstream stalls through a one-entry skid buffer and redirects on branch/flush, discarding stale in-flight fetches. An empty output slot is presented as 32'h0, the same NOP encoding IF/ID loads on flush.

## Interface
- RESET_PC, 32'h0000_0000, PC after reset; must be word-aligned.
- clk_i  in  1  clock, all state on rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- start_i  in  1  pipeline run enable; same signal IF/ID receives.
- stall_i  in  1  IF/ID hold; same signal IF/ID receives.
- branch_i  in  1  redirect/flush request; same cycle IF/ID is flushed.
- branch_target_i  in  32  redirect PC; bits [1:0] ignored (forced 2'b00).
- imem_req_o  out  1  memory request.
- imem_addr_o  out  32  request address; equals the internal PC.
- imem_ack_i  in  1  read data valid this cycle; only meaningful while imem_req_o=1.
- imem_rdata_i  in  32  instruction word.
- inst_o  out  32  instruction to IF/ID; 32'h0 when inst_valid_o=0.
- pc_o  out  32  PC of inst_o.
- inst_valid_o  out  1  output slot holds a real instruction.

## Operation
- consume = start_i & ~stall_i & ~branch_i. At any edge where this is 1, IF/ID takes the slot, so the slot is free for refill.
- States:
  - IDLE: imem_req_o=0.
  - FETCH: imem_req_o=1.
  - SKID: slot and skid buffer both full; imem_req_o=0.
  - DROP: imem_req_o=1; waiting for the stale ack.
- IDLE → FETCH on the first edge with start_i=1.
- Once in FETCH, the block never returns to IDLE except by reset.
- FETCH rules: imem_addr_o holds the PC until ack. Every update below also leaves the block in FETCH unless stated otherwise.
  - Ack, and (slot empty or consume): slot ← {rdata, PC}, inst_valid_o=1, PC ← PC+4.
  - Ack, slot full, no consume: skid ← {rdata, PC}, PC ← PC+4, go to SKID.
  - No ack, consume: slot empties; inst_o=0, inst_valid_o=0.
- SKID: on consume, slot ← skid and skid is cleared, then go to FETCH.
- Branch (branch_i=1 at an edge, any non-IDLE state): priority over everything else, including stall_i and ack.
  - Slot and skid cleared; inst_o=0, inst_valid_o=0.
  - PC ← target.
  - If a request was outstanding and was not acked that edge, go to DROP. Otherwise go to FETCH.
- DROP: the ack is discarded and nothing is loaded, then go to FETCH at the new PC. A branch while in DROP only updates PC and stays in DROP.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0.
- Reset (async, any state, mid-request included):
  - state = IDLE, PC = RESET_PC.
  - imem_req_o = 0 immediately.
  - inst_o = 0, pc_o = RESET_PC, inst_valid_o = 0, skid empty.
  - The memory side must tolerate an abandoned request.

## Timing
- imem_ack_i is sampled at the edge while imem_req_o=1. A zero-wait memory may ack in the same cycle as the request.
- Zero-wait throughput: 1 instruction/cycle. Request at cycle N, ack in N, inst_o valid in N+1, next request (PC+4) in N+1.
- Fetch-to-output latency: 1 edge after ack.
- Output to IF/ID: IF/ID captures inst_o at the same edge this block counts as consume.
- Stall rise: at most one extra instruction is accepted (into the skid) and then the request drops. Requests resume the cycle after stall falls.
- Branch to first target request: the next cycle if no request is stale. Otherwise the cycle after the stale ack.
- All outputs are registered or decoded from state/PC; there is no combinational path from the imem_* inputs to any output.

## Test plan
- Reset/start: hold rst_n_i=0 → imem_req_o=0, inst_o=0, pc_o=RESET_PC, inst_valid_o=0. Release, start_i=1 → next cycle imem_req_o=1, imem_addr_o=0x0.
- Zero-wait stream: ack every cycle, rdata=addr ^ 32'hA5A5_0000 → inst_o sequence 0xA5A50000, 0xA5A50004, 0xA5A50008 on consecutive cycles with pc_o 0x0, 0x4, 0x8.
- Stall/skid:
  - Stimulus: stall_i=1 for 3 cycles starting when inst_o shows PC 0x4.
  - During the stall: inst_o holds PC 0x4, the skid holds PC 0x8, imem_req_o=0.
  - After stall_i falls: PC 0x8 is presented on the next edge, then a request to 0xC.
- Branch on slow fetch: ack delay 2 cycles; branch_i with target 0x103 while the request to 0x10 is outstanding.
  - Immediately: inst_valid_o=0, inst_o=0.
  - The stale ack data is never output.
  - The next request has imem_addr_o=0x100.
- Branch+stall same edge, slot full: branch wins → slot cleared, imem_addr_o=target next cycle.
- Wrap: RESET_PC=32'hFFFF_FFFC with zero-wait memory → requests 0xFFFFFFFC, then 0x0. Also assert rst_n_i mid-request → imem_req_o falls without waiting for a clock.
